// File: rtl/xor_nibble_pack.sv
`default_nettype none
// ============================================================================
//  Module   : xor_nibble_pack
//  Purpose  : Packs successive XOR-stage result nibbles into one wide word and
//             presents it on a valid/ready port. Supports early flush of a
//             partial word (zero-padded) with a valid-nibble count and a
//             parity bit equal to the XOR-reduction of the word.
//  Revision : 1.0 - initial release
// ============================================================================
module xor_nibble_pack #(
  parameter int NIB_W   = 4,
  parameter int NIB_NUM = 4,
  parameter int CNT_W   = $clog2(NIB_NUM + 1)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  input  logic [NIB_W-1:0]         in_data,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NIB_W*NIB_NUM-1:0] out_data,
  output logic [CNT_W-1:0]         out_nibs,
  output logic                     out_par
);

  localparam int              c_WORD_W = NIB_W * NIB_NUM;
  localparam logic [CNT_W-1:0] c_LAST  = CNT_W'(NIB_NUM - 1);
  localparam logic [CNT_W-1:0] c_ZERO  = '0;

  // Assembly state
  logic [c_WORD_W-1:0] r_asm_buf;
  logic [CNT_W-1:0]    r_asm_cnt;
  logic                r_flush_pend;

  // Combinational control
  logic                w_slot_free;
  logic                w_accept;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [c_WORD_W-1:0] w_merged;
  logic                w_full;
  logic                w_flush_req;
  logic                w_has_data;
  logic                w_transfer;

  // Output register is free when empty or being drained on this edge.
  assign w_slot_free = !out_valid | out_ready;

  // Lanes below the last one are always accepted unless a flush is active or
  // pending; the last lane (and a flush-edge nibble) needs a free output slot
  // because it forces a transfer on the same edge.
  assign in_ready = (!r_flush_pend & !flush & ((r_asm_cnt < c_LAST) | w_slot_free))
                  | (flush & w_slot_free);

  assign w_accept    = in_valid & in_ready;
  assign w_cnt_next  = r_asm_cnt + {{(CNT_W-1){1'b0}}, w_accept};
  assign w_full      = w_accept & (r_asm_cnt == c_LAST);
  assign w_flush_req = flush | r_flush_pend;
  assign w_has_data  = (w_cnt_next != c_ZERO);
  assign w_transfer  = w_full | (w_flush_req & w_has_data & w_slot_free);

  // Buffer as it would look with this edge's nibble written into its lane.
  always_comb begin
    w_merged = r_asm_buf;
    for (int l = 0; l < NIB_NUM; l++) begin
      if (w_accept && (r_asm_cnt == CNT_W'(l))) begin
        w_merged[l*NIB_W +: NIB_W] = in_data;
      end
    end
  end

  // Assembly buffer and lane counter: fill on accept, clear on transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_asm_buf <= '0;
      r_asm_cnt <= '0;
    end else if (w_transfer) begin
      r_asm_buf <= '0;
      r_asm_cnt <= '0;
    end else if (w_accept) begin
      r_asm_buf <= w_merged;
      r_asm_cnt <= w_cnt_next;
    end
  end

  // Remember a flush that could not be honoured because the output was stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_flush_pend <= 1'b0;
    end else if (w_transfer) begin
      r_flush_pend <= 1'b0;
    end else if (flush && w_has_data) begin
      r_flush_pend <= 1'b1;
    end
  end

  // Output register: load on transfer, otherwise drop valid once drained.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_nibs  <= '0;
      out_par   <= 1'b0;
    end else if (w_transfer) begin
      out_valid <= 1'b1;
      out_data  <= w_merged;
      out_nibs  <= w_cnt_next;
      out_par   <= ^w_merged;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xor_nibble_pack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xor_nibble_pack
//  Purpose  : Self-checking bench for xor_nibble_pack. Expected words are
//             queued when the completing stimulus is driven and compared when
//             the DUT hands a word off on its output port.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_xor_nibble_pack;

  localparam int NIB_W   = 4;
  localparam int NIB_NUM = 4;
  localparam int CNT_W   = 3;
  localparam int WORD_W  = NIB_W * NIB_NUM;

  logic              clk = 1'b0;
  logic              rstn;
  logic              in_valid;
  logic [NIB_W-1:0]  in_data;
  logic              in_ready;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic [CNT_W-1:0]  out_nibs;
  logic              out_par;

  int vectors     = 0;
  int miscompares = 0;
  int words_seen  = 0;

  // {data, nibs, par}
  logic [WORD_W+CNT_W:0] exp_q[$];

  xor_nibble_pack #(
    .NIB_W  (NIB_W),
    .NIB_NUM(NIB_NUM),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_nibs (out_nibs),
    .out_par  (out_par)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scoreboard: a word is consumed at the edge following a negedge that sees
  // out_valid & out_ready.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      logic [WORD_W+CNT_W:0] e;
      vectors++;
      words_seen++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_unexpected: got data=%h nibs=%0d par=%0b, none expected",
                 out_data, out_nibs, out_par);
      end else begin
        e = exp_q.pop_front();
        if ({out_data, out_nibs, out_par} !== e) begin
          miscompares++;
          $display("FAIL scoreboard_word: got data=%h nibs=%0d par=%0b, expected data=%h nibs=%0d par=%0b",
                   out_data, out_nibs, out_par, e[WORD_W+CNT_W:CNT_W+1], e[CNT_W:1], e[0]);
        end
      end
    end
  end

  function automatic logic [WORD_W+CNT_W:0] mk(input logic [WORD_W-1:0] d, input int n);
    return {d, CNT_W'(n), ^d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one nibble and hold it until accepted.
  task automatic send(input logic [NIB_W-1:0] d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      $display("FAIL send_timeout: nibble %h not accepted in 50 cycles", d);
      $fatal(1);
    end
    tick();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({out_valid, out_data, out_nibs, out_par} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%0b data=%h nibs=%0d par=%0b, expected all 0",
               out_valid, out_data, out_nibs, out_par);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %0b expected 1", in_ready);
    end
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_full_word();
    out_ready = 1'b1;
    exp_q.push_back(mk(16'hA1F6, 4));
    send(4'h6); send(4'hF); send(4'h1);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL full_early_valid: got out_valid=%0b expected 0 before 4th nibble", out_valid);
    end
    tick();
    send(4'hA);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 16'hA1F6) begin
      miscompares++;
      $display("FAIL full_latency: got valid=%0b data=%h expected valid=1 data=a1f6", out_valid, out_data);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL full_one_cycle: got out_valid=%0b expected 0", out_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid_word();
    int seen0;
    out_ready = 1'b1;
    send(4'h6); send(4'hF);
    rstn = 1'b0;
    #3;
    rstn = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got valid=%0b data=%h expected 0/0000", out_valid, out_data);
    end
    tick();
    seen0 = words_seen;
    exp_q.push_back(mk(16'h4321, 4));
    send(4'h1); send(4'h2); send(4'h3); send(4'h4);
    repeat (3) tick();
    vectors++;
    if (words_seen - seen0 !== 1) begin
      miscompares++;
      $display("FAIL midreset_word_count: got %0d words expected 1", words_seen - seen0);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(4'h1); send(4'h2); send(4'h3);
    exp_q.push_back(mk(16'h4321, 4));
    send(4'h4);
    send(4'h5); send(4'h6); send(4'h7);
    exp_q.push_back(mk(16'h8765, 4));
    in_valid = 1'b1;
    in_data  = 4'h8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_in_ready_low: cycle %0d got %0b expected 0", i, in_ready);
      end
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 16'h4321 || out_nibs !== 3'd4) begin
        miscompares++;
        $display("FAIL bp_hold: cycle %0d got valid=%0b data=%h nibs=%0d expected 1/4321/4",
                 i, out_valid, out_data, out_nibs);
      end
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_in_ready_release: got %0b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 16'h8765) begin
      miscompares++;
      $display("FAIL bp_no_bubble: got valid=%0b data=%h expected 1/8765", out_valid, out_data);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drained: got out_valid=%0b expected 0", out_valid);
    end
    tick();
  endtask

  task automatic test_flush_partial();
    out_ready = 1'b1;
    send(4'h6); send(4'hF);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'h1;
    exp_q.push_back(mk(16'h01F6, 3));
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_in_ready: got %0b expected 1", in_ready);
    end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_nibs !== 3'd3 || out_data !== 16'h01F6) begin
      miscompares++;
      $display("FAIL flush_partial: got valid=%0b data=%h nibs=%0d expected 1/01f6/3",
               out_valid, out_data, out_nibs);
    end
    tick();
  endtask

  task automatic test_flush_stall();
    out_ready = 1'b0;
    exp_q.push_back(mk(16'h4321, 4));
    send(4'h1); send(4'h2); send(4'h3); send(4'h4);
    send(4'h9);
    flush = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_flush_in_ready: got %0b expected 0", in_ready);
    end
    tick();
    flush = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0 || out_data !== 16'h4321) begin
      miscompares++;
      $display("FAIL stall_pending: got in_ready=%0b data=%h expected 0/4321", in_ready, out_data);
    end
    tick();
    exp_q.push_back(mk(16'h0009, 1));
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_pending_release: got in_ready=%0b expected 0", in_ready);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 16'h0009 || out_nibs !== 3'd1 || out_par !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_flushed_word: got valid=%0b data=%h nibs=%0d par=%0b expected 1/0009/1/0",
               out_valid, out_data, out_nibs, out_par);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_pend_cleared: got in_ready=%0b expected 1", in_ready);
    end
    tick();
    tick();
  endtask

  task automatic test_flush_empty();
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL flush_empty: cycle %0d got out_valid=%0b in_ready=%0b expected 0/1",
                 i, out_valid, in_ready);
      end
      tick();
    end
  endtask

  task automatic test_drain_final();
    repeat (3) tick();
    vectors++;
    if (exp_q.size() !== 0 || words_seen !== 7) begin
      miscompares++;
      $display("FAIL final_drain: got %0d pending, %0d words seen; expected 0 pending, 7 words",
               exp_q.size(), words_seen);
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_reset_mid_word();
    test_backpressure();
    test_flush_partial();
    test_flush_stall();
    test_flush_empty();
    test_drain_final();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
